flow_row_arbiter: RTL and testbench

- Upstream neighbour of the multi-flow interpolation filter (`top_ms`).
- Takes FLUX independent untagged pixel streams, each with its own extended block size.
- Merges them onto the single tagged `in_port` write interface, interleaving one full row (`ext_size` pixels) per flow turn, round-robin.
- Honours per-flow downstream `full`, and signals per-flow completion after `ext_size × ext_size` pixels.

---
 rtl/flow_row_arbiter_pkg.sv | 30 +++
 rtl/flow_row_arbiter_if.sv | 28 ++
 rtl/flow_row_arbiter_buf2.sv | 47 ++++
 rtl/flow_row_arbiter.sv | 162 ++++++++++++++++
 tb/tb_flow_row_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flow_row_arbiter_pkg.sv
// Shared constants and types for the row-interleaving flow arbiter.
// Tag and pixel layouts match the downstream filter's in_port word.
package flow_pkg;

    localparam int FLUX   = 2;
    localparam int DATA_W = 8;
    localparam int SIZE_W = 7;
    localparam int TAG_W  = (FLUX > 1) ? $clog2(FLUX) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] pel;
    } tagged_pel_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [SIZE_W-1:0] size;
    } cfg_t;

    // A tag field can encode more values than there are flows when FLUX is not a power of two.
    function automatic logic tag_valid(input logic [TAG_W-1:0] t);
        return 32'(t) < FLUX;
    endfunction

endpackage

// File: rtl/flow_row_arbiter_if.sv
// Bundle of configuration, per-flow source and tagged destination signals.
// The arbiter sits on the slave side; the environment drives the master side.
interface flow_row_arbiter_if;
    import flow_pkg::*;

    // Write/full semantics on both sides: a word moves on any cycle where write is high and
    // the matching full was low at the start of that cycle; a write while full is dropped.
    logic [TAG_W+SIZE_W-1:0] cfg_din;
    logic                    cfg_write;
    logic [FLUX*DATA_W-1:0]  src_din;
    logic [FLUX-1:0]         src_write;
    logic [FLUX-1:0]         src_full;
    logic [TAG_W+DATA_W-1:0] dst_din;
    logic                    dst_write;
    logic [FLUX-1:0]         dst_full;
    logic [FLUX-1:0]         flow_done;

    modport master (
        output cfg_din, cfg_write, src_din, src_write, dst_full,
        input  src_full, dst_din, dst_write, flow_done
    );

    modport slave (
        input  cfg_din, cfg_write, src_din, src_write, dst_full,
        output src_full, dst_din, dst_write, flow_done
    );

endinterface

// File: rtl/flow_row_arbiter_buf2.sv
// Two-entry FIFO holding one flow's pixels until the arbiter selects that flow.
// Writes while full are discarded; push and pop may share a cycle.
module flow_buf2
    import flow_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              write,
    output logic              full,
    output logic [DATA_W-1:0] dout,
    input  logic              read,
    output logic              empty
);

    logic [DATA_W-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    assign push = write && (count != 2'd2);
    assign pop  = read && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/flow_row_arbiter.sv
// Merges FLUX untagged pixel streams onto one tagged write port, one full row per turn,
// round-robin, and pulses flow_done on the last pixel of each ext_size x ext_size block.
module flow_row_arbiter
    import flow_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    flow_row_arbiter_if.slave  bus,
    output arb_state_t         state
);

    arb_state_t        state_next;
    logic [TAG_W-1:0]  cur;
    logic [TAG_W-1:0]  cur_next;

    logic [FLUX-1:0]   active;
    logic [FLUX-1:0]   active_kept;
    logic [FLUX-1:0]   active_next;
    logic [SIZE_W-1:0] size    [FLUX];
    logic [SIZE_W-1:0] pel_cnt [FLUX];
    logic [SIZE_W-1:0] row_cnt [FLUX];

    logic [FLUX-1:0]   buf_empty;
    logic [FLUX-1:0]   buf_full;
    logic [FLUX-1:0]   buf_read;
    logic [DATA_W-1:0] buf_head [FLUX];

    logic              emit;
    logic              row_end;
    logic              flow_end;
    logic              cfg_ok;
    cfg_t              cfg;
    tagged_pel_t       pel_out;
    logic [FLUX-1:0]   done_vec;
    logic              found;
    int                idx;

    for (genvar i = 0; i < FLUX; i++) begin : g_buf
        flow_buf2 u_buf (
            .clk   (clk),
            .rst   (rst),
            .din   (bus.src_din[i*DATA_W +: DATA_W]),
            .write (bus.src_write[i]),
            .full  (buf_full[i]),
            .dout  (buf_head[i]),
            .read  (buf_read[i]),
            .empty (buf_empty[i])
        );
    end

    assign cfg = cfg_t'(bus.cfg_din);

    // Emission and the active set as seen by this cycle's decisions.
    always_comb begin
        emit     = !rst && (state == STREAM) && active[cur] && !buf_empty[cur] && !bus.dst_full[cur];
        row_end  = emit && (pel_cnt[cur] == size[cur] - SIZE_W'(1));
        flow_end = row_end && (row_cnt[cur] == size[cur] - SIZE_W'(1));

        active_kept = active;
        if (flow_end) begin
            active_kept[cur] = 1'b0;
        end

        cfg_ok = bus.cfg_write && (cfg.size != '0) && tag_valid(cfg.tag) && !active_kept[cfg.tag];

        active_next = active_kept;
        if (cfg_ok) begin
            active_next[cfg.tag] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cur   <= '0;
        end else begin
            state <= state_next;
            cur   <= cur_next;
        end
    end

    // A configuration landing on the rotation cycle is not yet eligible: STREAM picks from
    // active_kept, while IDLE wakes on anything in active_next.
    always_comb begin
        state_next = state;
        cur_next   = cur;
        found      = 1'b0;
        idx        = 0;
        case (state)
            IDLE: begin
                if (|active_next) begin
                    state_next = STREAM;
                    for (int k = FLUX - 1; k >= 0; k--) begin
                        if (active_next[k]) begin
                            cur_next = TAG_W'(k);
                        end
                    end
                end
            end
            STREAM: begin
                if (row_end) begin
                    for (int k = 1; k <= FLUX; k++) begin
                        idx = (int'(cur) + k) % FLUX;
                        if (!found && active_kept[idx]) begin
                            found    = 1'b1;
                            cur_next = TAG_W'(idx);
                        end
                    end
                    if (!found) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pel_out.tag = cur;
        pel_out.pel = buf_head[cur];
        done_vec    = '0;
        buf_read    = '0;
        if (flow_end) begin
            done_vec[cur] = 1'b1;
        end
        if (emit) begin
            buf_read[cur] = 1'b1;
        end
        bus.dst_write = emit;
        bus.dst_din   = emit ? pel_out : '0;
        bus.flow_done = done_vec;
        bus.src_full  = rst ? '0 : buf_full;
    end

    // A same-cycle configuration overrides the finishing flow's counter updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
            for (int i = 0; i < FLUX; i++) begin
                size[i]    <= '0;
                pel_cnt[i] <= '0;
                row_cnt[i] <= '0;
            end
        end else begin
            active <= active_next;
            if (emit) begin
                if (row_end) begin
                    pel_cnt[cur] <= '0;
                    row_cnt[cur] <= row_cnt[cur] + SIZE_W'(1);
                end else begin
                    pel_cnt[cur] <= pel_cnt[cur] + SIZE_W'(1);
                end
            end
            if (cfg_ok) begin
                size[cfg.tag]    <= cfg.size;
                pel_cnt[cfg.tag] <= '0;
                row_cnt[cfg.tag] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_flow_row_arbiter.sv
// Directed bench for flow_row_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_flow_row_arbiter;
  import flow_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flow_row_arbiter_if bus();
  arb_state_t state;

  flow_row_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] exp_q [FLUX][$];
  bit m_act [FLUX];
  bit keep [FLUX];
  int m_size [FLUX];
  int m_row_left [FLUX];
  int m_left [FLUX];
  int m_cur = 0;
  bit m_stream = 1'b0;

  bit wr, rend, fend, cfg_ok, found;
  bit full_pre [FLUX];
  int t_cfg, sz_cfg, j;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) begin
        exp_q[i].delete();
        m_act[i] = 0; m_size[i] = 0; m_row_left[i] = 0; m_left[i] = 0;
      end
      m_cur = 0;
      m_stream = 0;
    end else begin
      for (int i = 0; i < FLUX; i++) full_pre[i] = (exp_q[i].size() == 2);
      wr = m_stream && m_act[m_cur] && (exp_q[m_cur].size() > 0) && !bus.dst_full[m_cur];
      rend = 0;
      fend = 0;
      if (wr) begin
        void'(exp_q[m_cur].pop_front());
        m_row_left[m_cur]--;
        m_left[m_cur]--;
        rend = (m_row_left[m_cur] == 0);
        if (rend) m_row_left[m_cur] = m_size[m_cur];
        fend = (m_left[m_cur] == 0);
        if (fend) m_act[m_cur] = 0;
      end
      for (int i = 0; i < FLUX; i++)
        if (bus.src_write[i] && !full_pre[i]) exp_q[i].push_back(bus.src_din[i*DATA_W +: DATA_W]);
      keep = m_act;
      t_cfg = int'(bus.cfg_din[SIZE_W +: TAG_W]);
      sz_cfg = int'(bus.cfg_din[SIZE_W-1:0]);
      cfg_ok = bus.cfg_write && (sz_cfg != 0) && (t_cfg < FLUX) && !m_act[t_cfg];
      if (cfg_ok) begin
        m_act[t_cfg] = 1;
        m_size[t_cfg] = sz_cfg;
        m_row_left[t_cfg] = sz_cfg;
        m_left[t_cfg] = sz_cfg * sz_cfg;
      end
      if (m_stream) begin
        if (rend) begin
          found = 0;
          for (int k = 1; k <= FLUX; k++) begin
            j = (m_cur + k) % FLUX;
            if (!found && keep[j]) begin found = 1; m_cur = j; end
          end
          if (!found) m_stream = 0;
        end
      end else begin
        found = 0;
        for (int k = 0; k < FLUX; k++)
          if (!found && m_act[k]) begin found = 1; m_cur = k; m_stream = 1; end
      end
    end
  end

  // ---------------- per-cycle compare and write log ----------------
  logic [TAG_W-1:0] tag_log [$];
  int w_cnt [FLUX];
  int done_cnt [FLUX];
  int done_at [FLUX];
  int total_w = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic e_wr;
  logic [TAG_W+DATA_W-1:0] e_din;
  logic [FLUX-1:0] e_done, e_full;

  always @(negedge clk) begin
    e_wr = !rst && m_stream && m_act[m_cur] && (exp_q[m_cur].size() > 0) && !bus.dst_full[m_cur];
    e_din = '0;
    e_done = '0;
    if (e_wr) begin
      e_din = {TAG_W'(m_cur), exp_q[m_cur][0]};
      if (m_left[m_cur] == 1) e_done[m_cur] = 1'b1;
    end
    for (int i = 0; i < FLUX; i++) e_full[i] = !rst && (exp_q[i].size() == 2);
    check("cycle {state,write,din,done,src_full}",
          32'({state == STREAM, bus.dst_write, bus.dst_din, bus.flow_done, bus.src_full}),
          32'({m_stream, e_wr, e_din, e_done, e_full}));
    if (bus.dst_write) begin
      tag_log.push_back(bus.dst_din[DATA_W +: TAG_W]);
      w_cnt[int'(bus.dst_din[DATA_W +: TAG_W])]++;
      total_w++;
      if (total_w == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
    for (int i = 0; i < FLUX; i++)
      if (bus.flow_done[i]) begin done_cnt[i]++; done_at[i] = total_w; end
  end

  // ---------------- source drivers ----------------
  bit feed_en [FLUX];
  int feed_left [FLUX];
  logic [DATA_W-1:0] feed_val [FLUX];

  initial begin
    bus.src_write = '0;
    bus.src_din = '0;
    for (int i = 0; i < FLUX; i++) begin
      feed_en[i] = 0; feed_left[i] = 0; feed_val[i] = DATA_W'(i * 128 + 3);
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < FLUX; i++) begin
        if (feed_en[i] && feed_left[i] > 0 && !bus.src_full[i]) begin
          bus.src_write[i] = 1'b1;
          bus.src_din[i*DATA_W +: DATA_W] = feed_val[i];
          feed_val[i]++;
          feed_left[i]--;
        end else begin
          bus.src_write[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic feed(input int f, input int n);
    feed_en[f] = 1;
    feed_left[f] += n;
  endtask

  task automatic cfg(input int tag, input int sz);
    bus.cfg_din = {TAG_W'(tag), SIZE_W'(sz)};
    bus.cfg_write = 1'b1;
    tick();
    bus.cfg_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cfg_write = 1'b0;
    bus.dst_full = '0;
    for (int i = 0; i < FLUX; i++) begin feed_en[i] = 0; feed_left[i] = 0; end
    tick();
    tick();
    rst = 1'b0;
    tag_log.delete();
    total_w = 0;
    for (int i = 0; i < FLUX; i++) begin w_cnt[i] = 0; done_cnt[i] = 0; done_at[i] = 0; end
    check("post_reset_outputs", 32'({bus.dst_write, bus.dst_din, bus.flow_done, bus.src_full}), 32'd0);
    check("post_reset_state", 32'(state), 32'(IDLE));
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int k = 0;
    while (total_w < n && k < budget) begin tick(); k++; end
    check(name, total_w, n);
  endtask

  task automatic wait_flow(input int f, input int n, input int budget, input string name);
    int k = 0;
    while (w_cnt[f] < n && k < budget) begin tick(); k++; end
    check(name, w_cnt[f], n);
  endtask

  function automatic int count_tag(input int lo, input int hi, input int t);
    int c = 0;
    for (int k = lo; k <= hi && k < tag_log.size(); k++)
      if (int'(tag_log[k]) == t) c++;
    return c;
  endfunction

  function automatic int last_index(input int t);
    int r = -1;
    for (int k = 0; k < tag_log.size(); k++)
      if (int'(tag_log[k]) == t) r = k;
    return r;
  endfunction

  int hold_base;
  int resume_tag;

  initial begin
    bus.cfg_din = '0;
    bus.cfg_write = 1'b0;
    bus.dst_full = '0;
    do_reset();

    // single flow, 11x11
    feed(0, 121);
    cfg(0, 11);
    wait_writes(121, 400, "t1_total");
    repeat (3) tick();
    check("t1_flow0_writes", w_cnt[0], 121);
    check("t1_done_cnt", done_cnt[0], 1);
    check("t1_done_on_write", done_at[0], 121);
    check("t1_span", last_cyc - first_cyc, 120);
    check("t1_idle", 32'(state), 32'(IDLE));

    // two flows, 15 and 39, row interleave
    do_reset();
    feed(0, 225);
    feed(1, 1521);
    cfg(0, 15);
    cfg(1, 39);
    wait_writes(1746, 2400, "t2_total");
    repeat (3) tick();
    check("t2_first_row_tag0", count_tag(0, 14, 0), 15);
    check("t2_second_row_tag1", count_tag(15, 53, 1), 39);
    check("t2_third_row_tag0", count_tag(54, 54, 0), 1);
    check("t2_last_tag0_index", last_index(0), 770);
    check("t2_flow0_writes", w_cnt[0], 225);
    check("t2_flow1_writes", w_cnt[1], 1521);
    check("t2_span", last_cyc - first_cyc, 1745);
    check("t2_done", 32'({done_cnt[0][3:0], done_cnt[1][3:0]}), 32'h11);

    // backpressure on flow 1 mid-row
    do_reset();
    feed(1, 121);
    feed(0, 25);
    cfg(1, 11);
    cfg(0, 5);
    wait_flow(1, 10, 100, "t3_reach10");
    bus.dst_full[1] = 1'b1;
    hold_base = total_w;
    check("t3_hold_base", hold_base, 10);
    repeat (2) tick();
    check("t3_src_full1", 32'(bus.src_full[1]), 32'd1);
    repeat (18) tick();
    check("t3_hold_writes", total_w, hold_base);
    bus.dst_full[1] = 1'b0;
    tick();
    resume_tag = (tag_log.size() > 10) ? int'(tag_log[10]) : 7;
    check("t3_resume_tag", resume_tag, 1);
    wait_writes(146, 500, "t3_total");
    check("t3_flow1_writes", w_cnt[1], 121);
    check("t3_flow0_writes", w_cnt[0], 25);

    // flow 0 starved mid-row while flow 1 waits
    do_reset();
    feed(1, 225);
    feed(0, 7);
    cfg(0, 15);
    cfg(1, 15);
    wait_writes(7, 100, "t4_pre_starve");
    repeat (30) tick();
    check("t4_starve_writes", total_w, 7);
    feed(0, 218);
    wait_writes(450, 1200, "t4_total");
    check("t4_first_row_tag0", count_tag(0, 14, 0), 15);
    check("t4_then_tag1", count_tag(15, 15, 1), 1);
    check("t4_flow0_writes", w_cnt[0], 225);

    // configuration rules and reload at flow end
    do_reset();
    feed(0, 450);
    feed(1, 9);
    cfg(0, 15);
    cfg(0, 5);
    cfg(1, 0);
    cfg(1, 3);
    wait_flow(0, 224, 800, "t5_reach224");
    cfg(0, 15);
    check("t5_end_write", w_cnt[0], 225);
    check("t5_done_on_reload", done_cnt[0], 1);
    wait_writes(459, 1200, "t5_total");
    repeat (3) tick();
    check("t5_row_len_kept", count_tag(0, 14, 0), 15);
    check("t5_size3_row", count_tag(15, 17, 1), 3);
    check("t5_flow1_writes", w_cnt[1], 9);
    check("t5_flow0_done2", done_cnt[0], 2);

    // reset mid-row
    do_reset();
    feed(0, 200);
    cfg(0, 11);
    wait_writes(50, 200, "t6_reach50");
    feed_en[0] = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_after_rst_write", 32'(bus.dst_write), 32'd0);
    check("t6_after_rst_src_full", 32'(bus.src_full), 32'd0);
    feed_en[0] = 1;
    repeat (30) tick();
    check("t6_no_writes", total_w, 50);
    feed(1, 121);
    cfg(1, 11);
    wait_flow(1, 121, 400, "t6_flow1_run");
    repeat (3) tick();
    check("t6_flow0_frozen", w_cnt[0], 50);
    check("t6_flow1_done", done_cnt[1], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
